// File: rtl/car_motion.sv
// Car motion executor: moves the car one floor per travel period toward the target from `state`,
// runs the door dwell, and reports floor/arrival. Optional macro CAR_SEG_EN adds a 7-seg floor display.
module car_motion #(
    parameter int TRAVEL_CYC = 2000,
    parameter int DOOR_CYC   = 3000
) (
    input  logic       clk_1KHz,
    input  logic       rst_n,
    input  logic [1:0] drc,
    input  logic [1:0] t_floor,
    input  logic       door_req_n,
`ifdef CAR_SEG_EN
    output logic [6:0] seg_n,
`endif
    output logic [1:0] c_floor,
    output logic       arrival,
    output logic       door_open,
    output logic       moving
);

    localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;

    logic [1:0]    state, state_nx;
    logic [1:0]    floor_nx, step_floor;
    logic [TW-1:0] timer, timer_nx;
    logic          dir_up, dir_up_nx;
    logic          stop_here;

    // One shared timer: travel period in MOVE, dwell in DOOR; cleared whenever a state is entered.
    always_comb begin
        state_nx   = state;
        floor_nx   = c_floor;
        timer_nx   = timer;
        dir_up_nx  = dir_up;
        step_floor = c_floor;
        stop_here  = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nx = '0;
                if (drc == 2'b01 && t_floor > c_floor) begin
                    state_nx  = S_MOVE;
                    dir_up_nx = 1'b1;
                end else if (drc == 2'b10 && t_floor < c_floor) begin
                    state_nx  = S_MOVE;
                    dir_up_nx = 1'b0;
                end else if (!door_req_n) begin
                    state_nx = S_DOOR;
                end
            end
            S_MOVE: begin
                if (timer == TRAVEL_LAST) begin
                    step_floor = dir_up ? (c_floor + 2'd1) : (c_floor - 2'd1);
                    floor_nx   = step_floor;
                    timer_nx   = '0;
                    // Retargeting and direction changes are honoured only at a floor boundary.
                    stop_here  = (step_floor == t_floor)
                               || (drc == 2'b00) || (drc == 2'b11)
                               || (dir_up && drc == 2'b10)
                               || (!dir_up && drc == 2'b01)
                               || (dir_up && step_floor == 2'd3)
                               || (!dir_up && step_floor == 2'd0);
                    if (stop_here) begin
                        state_nx = S_DOOR;
                    end
                end else begin
                    timer_nx = timer + TIMER_ONE;
                end
            end
            S_DOOR: begin
                if (!door_req_n) begin
                    timer_nx = '0;
                end else if (timer == DOOR_LAST) begin
                    state_nx = S_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + TIMER_ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            c_floor   <= 2'd0;
            timer     <= '0;
            dir_up    <= 1'b0;
            arrival   <= 1'b1;
            door_open <= 1'b0;
            moving    <= 1'b0;
        end else begin
            state     <= state_nx;
            c_floor   <= floor_nx;
            timer     <= timer_nx;
            dir_up    <= dir_up_nx;
            arrival   <= (state_nx != S_MOVE);
            door_open <= (state_nx == S_DOOR);
            moving    <= (state_nx == S_MOVE);
        end
    end

`ifdef CAR_SEG_EN
    // Display shows floor+1 on a common-anode digit, segment order gfedcba.
    function automatic logic [6:0] seg_of(input logic [1:0] f);
        case (f)
            2'd0:    seg_of = 7'b1111001;
            2'd1:    seg_of = 7'b0100100;
            2'd2:    seg_of = 7'b0110000;
            default: seg_of = 7'b0011001;
        endcase
    endfunction

    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= 7'b1111001;
        end else begin
            seg_n <= seg_of(floor_nx);
        end
    end
`endif

endmodule
